alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/cpu_pkg.sv | 22 ++
 rtl/alu_arbiter_if.sv | 39 +++
 rtl/alu_arbiter_rr_picker.sv | 28 ++
 rtl/alu_arbiter.sv | 116 +++++++++++
 tb/tb_alu_arbiter.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU types: ALU operation codes, ALU response payload and arbiter limits.
package cpu_pkg;

  localparam int unsigned DATA_W          = 32;
  localparam int unsigned ALU_ARB_MAX_REQ = 4;

  typedef enum logic [3:0] {
    ALU_ADD = 4'd0,
    ALU_SUB = 4'd1,
    ALU_AND = 4'd2,
    ALU_OR  = 4'd3,
    ALU_XOR = 4'd4,
    ALU_SLT = 4'd5
  } aluCode_t;

  typedef struct packed {
    logic signed [DATA_W-1:0] result;
    logic                     negative;
    logic                     zero;
  } alu_rsp_t;

endpackage

// File: rtl/alu_arbiter_if.sv
// Requester, response and ALU-side signals of the shared-ALU arbiter.
interface alu_arbiter_if #(
  parameter int unsigned N_REQ = 2
) ();

  logic [N_REQ-1:0]          req_valid;
  logic [N_REQ-1:0]          req_ready;
  logic signed [31:0]        req_a  [N_REQ];
  logic signed [31:0]        req_b  [N_REQ];
  cpu_pkg::aluCode_t         req_op [N_REQ];

  logic [N_REQ-1:0]          rsp_valid;
  logic [N_REQ-1:0]          rsp_ready;
  logic signed [31:0]        rsp_result;
  logic                      rsp_negative;
  logic                      rsp_zero;

  logic signed [31:0]        alu_inputA;
  logic signed [31:0]        alu_inputB;
  cpu_pkg::aluCode_t         alu_ALUOp;
  logic signed [31:0]        alu_ALUResult;
  logic                      alu_negative;
  logic                      alu_zero;

  modport slave (
    input  req_valid, req_a, req_b, req_op, rsp_ready,
           alu_ALUResult, alu_negative, alu_zero,
    output req_ready, rsp_valid, rsp_result, rsp_negative, rsp_zero,
           alu_inputA, alu_inputB, alu_ALUOp
  );

  modport master (
    output req_valid, req_a, req_b, req_op, rsp_ready,
           alu_ALUResult, alu_negative, alu_zero,
    input  req_ready, rsp_valid, rsp_result, rsp_negative, rsp_zero,
           alu_inputA, alu_inputB, alu_ALUOp
  );

endinterface

// File: rtl/alu_arbiter_rr_picker.sv
// Combinational picker: first set request at or after start_i (wrapping) wins, one-hot result.
module rr_picker #(
  parameter int unsigned N     = 2,
  parameter int unsigned PTR_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req_i,
  input  logic [PTR_W-1:0] start_i,
  output logic [N-1:0]     grant_c_o
);

  int unsigned idx;
  logic        found;

  always_comb begin
    grant_c_o = '0;
    found     = 1'b0;
    idx       = 0;
    for (int unsigned k = 0; k < N; k++) begin
      idx = 32'(start_i) + k;
      if (idx >= N) idx = idx - N;
      if (!found && req_i[PTR_W'(idx)]) begin
        grant_c_o[PTR_W'(idx)] = 1'b1;
        found                  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU among N_REQ requesters with a single registered result slot.
// Define ALU_ARB_RR_EN for round-robin arbitration; otherwise lowest index wins.
module alu_arbiter
  import cpu_pkg::*;
#(
  parameter int unsigned N_REQ = 2
) (
  input  logic          clk,
  input  logic          nRst,
  alu_arbiter_if.slave  bus
);

  localparam int unsigned PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_HOLD = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [N_REQ-1:0] rsp_valid_q, rsp_valid_d;
  alu_rsp_t         rsp_q, rsp_d;

  logic [PTR_W-1:0] start_c;
  logic [PTR_W-1:0] grant_idx_c;
  logic [N_REQ-1:0] pick_req_c;
  logic [N_REQ-1:0] grant_c;
  logic             consume_c;
  logic             grant_en_c;

`ifdef ALU_ARB_RR_EN
  logic [PTR_W-1:0] last_q, last_d;
  assign start_c = (last_q == PTR_W'(N_REQ - 1)) ? '0 : last_q + PTR_W'(1);
`else
  assign start_c = '0;
`endif

  // A new grant needs a free slot: either empty, or the pending result leaves this cycle.
  assign consume_c  = |(rsp_valid_q & bus.rsp_ready);
  assign grant_en_c = nRst && ((state_q == ST_IDLE) || consume_c);
  assign pick_req_c = bus.req_valid & {N_REQ{grant_en_c}};

  rr_picker #(
    .N     (N_REQ),
    .PTR_W (PTR_W)
  ) u_picker (
    .req_i     (pick_req_c),
    .start_i   (start_c),
    .grant_c_o (grant_c)
  );

  always_comb begin
    grant_idx_c = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (grant_c[i]) grant_idx_c = PTR_W'(i);
    end
  end

  // ALU operands follow the granted requester; idle value is 0 + 0.
  always_comb begin
    bus.alu_inputA = '0;
    bus.alu_inputB = '0;
    bus.alu_ALUOp  = ALU_ADD;
    if (|grant_c) begin
      bus.alu_inputA = bus.req_a[grant_idx_c];
      bus.alu_inputB = bus.req_b[grant_idx_c];
      bus.alu_ALUOp  = bus.req_op[grant_idx_c];
    end
  end

  always_comb begin
    state_d     = state_q;
    rsp_valid_d = rsp_valid_q;
    rsp_d       = rsp_q;
`ifdef ALU_ARB_RR_EN
    last_d      = last_q;
`endif
    if ((state_q == ST_HOLD) && consume_c) begin
      state_d     = ST_IDLE;
      rsp_valid_d = '0;
    end
    if (|grant_c) begin
      state_d        = ST_HOLD;
      rsp_valid_d    = grant_c;
      rsp_d.result   = bus.alu_ALUResult;
      rsp_d.negative = bus.alu_negative;
      rsp_d.zero     = bus.alu_zero;
`ifdef ALU_ARB_RR_EN
      last_d         = grant_idx_c;
`endif
    end
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state_q     <= ST_IDLE;
      rsp_valid_q <= '0;
      rsp_q       <= '0;
`ifdef ALU_ARB_RR_EN
      last_q      <= PTR_W'(N_REQ - 1);
`endif
    end else begin
      state_q     <= state_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_q       <= rsp_d;
`ifdef ALU_ARB_RR_EN
      last_q      <= last_d;
`endif
    end
  end

  assign bus.req_ready    = grant_c;
  assign bus.rsp_valid    = rsp_valid_q;
  assign bus.rsp_result   = rsp_q.result;
  assign bus.rsp_negative = rsp_q.negative;
  assign bus.rsp_zero     = rsp_q.zero;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: per-cycle comparison against a transaction-level model plus directed checks.
module tb_alu_arbiter;
  import cpu_pkg::*;

  localparam int N = 2;

  logic clk = 1'b0;
  logic nRst;
  int   n_cmp = 0;
  int   n_bad = 0;

  alu_arbiter_if #(.N_REQ(N)) bus ();

  alu_arbiter #(.N_REQ(N)) u_dut (
    .clk  (clk),
    .nRst (nRst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  function automatic logic signed [31:0] alu_f(aluCode_t op, logic signed [31:0] a, logic signed [31:0] b);
    case (op)
      ALU_ADD: return a + b;
      ALU_SUB: return a - b;
      ALU_AND: return a & b;
      ALU_OR:  return a | b;
      ALU_XOR: return a ^ b;
      ALU_SLT: return (a < b) ? 32'sd1 : 32'sd0;
      default: return 32'sd0;
    endcase
  endfunction

  // Behavioural combinational ALU seen by the arbiter.
  assign bus.alu_ALUResult = alu_f(bus.alu_ALUOp, bus.alu_inputA, bus.alu_inputB);
  assign bus.alu_negative  = bus.alu_ALUResult[31];
  assign bus.alu_zero      = (bus.alu_ALUResult == 32'sd0);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: one pending result slot, owner index or -1.
  int               m_pend = -1;
  int               m_last = N - 1;
  logic signed [31:0] m_res = '0;
  logic             m_neg = 1'b0;
  logic             m_zero = 1'b0;

  function automatic int exp_grant();
    int start;
    if (!nRst) return -1;
    if (m_pend >= 0 && !bus.rsp_ready[m_pend]) return -1;
`ifdef ALU_ARB_RR_EN
    start = (m_last + 1) % N;
`else
    start = 0;
`endif
    for (int k = 0; k < N; k++) begin
      int i;
      i = (start + k) % N;
      if (bus.req_valid[i]) return i;
    end
    return -1;
  endfunction

  always @(negedge nRst) begin
    m_pend = -1;
    m_last = N - 1;
    m_res  = '0;
    m_neg  = 1'b0;
    m_zero = 1'b0;
  end

  always @(posedge clk) begin
    int g;
    if (nRst) begin
      g = exp_grant();
      if (m_pend >= 0 && bus.rsp_ready[m_pend]) m_pend = -1;
      if (g >= 0) begin
        m_pend = g;
        m_last = g;
        m_res  = alu_f(bus.req_op[g], bus.req_a[g], bus.req_b[g]);
        m_neg  = m_res < 0;
        m_zero = m_res == 0;
      end
    end
  end

  always @(negedge clk) begin
    int g;
    g = exp_grant();
    chk("m_req_ready", 32'(bus.req_ready), (g >= 0) ? 32'(1 << g) : 32'd0);
    chk("m_alu_a", bus.alu_inputA, (g >= 0) ? bus.req_a[g] : 32'd0);
    chk("m_alu_b", bus.alu_inputB, (g >= 0) ? bus.req_b[g] : 32'd0);
    chk("m_alu_op", 32'(bus.alu_ALUOp), (g >= 0) ? 32'(bus.req_op[g]) : 32'(ALU_ADD));
    chk("m_rsp_valid", 32'(bus.rsp_valid), (m_pend >= 0) ? 32'(1 << m_pend) : 32'd0);
    chk("m_rsp_result", bus.rsp_result, m_res);
    chk("m_rsp_neg", 32'(bus.rsp_negative), 32'(m_neg));
    chk("m_rsp_zero", 32'(bus.rsp_zero), 32'(m_zero));
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    nRst          = 1'b0;
    bus.rsp_ready = '0;
    for (int i = 0; i < N; i++) begin
      bus.req_a[i]  = '0;
      bus.req_b[i]  = '0;
      bus.req_op[i] = ALU_ADD;
    end
    bus.req_valid = 2'b11;

    // Reset: no grants, cleared response.
    @(negedge clk);
    chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_rsp_result", bus.rsp_result, 32'd0);
    step();
    nRst          = 1'b1;
    bus.req_valid = '0;

    // Single op: 5 + (-7).
    bus.req_a[0]  = 32'sd5;
    bus.req_b[0]  = -32'sd7;
    bus.req_op[0] = ALU_ADD;
    bus.req_valid = 2'b01;
    @(negedge clk);
    chk("single_grant", 32'(bus.req_ready), 32'h1);
    chk("single_alu_a", bus.alu_inputA, 32'd5);
    step();
    bus.req_valid = '0;
    @(negedge clk);
    chk("single_rsp_valid", 32'(bus.rsp_valid), 32'h1);
    chk("single_result", bus.rsp_result, 32'hFFFF_FFFE);
    chk("single_neg", 32'(bus.rsp_negative), 32'd1);
    chk("single_zero", 32'(bus.rsp_zero), 32'd0);
    bus.rsp_ready = 2'b01;
    step();
    bus.rsp_ready = '0;
    @(negedge clk);
    chk("single_drained", 32'(bus.rsp_valid), 32'd0);

    // Zero flag: 9 - 9 on requester 1.
    bus.req_a[1]  = 32'sd9;
    bus.req_b[1]  = 32'sd9;
    bus.req_op[1] = ALU_SUB;
    bus.req_valid = 2'b10;
    step();
    bus.req_valid = '0;
    @(negedge clk);
    chk("zero_rsp_valid", 32'(bus.rsp_valid), 32'h2);
    chk("zero_result", bus.rsp_result, 32'd0);
    chk("zero_flag", 32'(bus.rsp_zero), 32'd1);
    chk("zero_neg", 32'(bus.rsp_negative), 32'd0);
    bus.rsp_ready = 2'b10;
    step();
    bus.rsp_ready = '0;

    // Contention from reset with results always consumed.
    nRst = 1'b0;
    step();
    nRst = 1'b1;
    bus.req_a[0]  = 32'sd1;  bus.req_b[0] = 32'sd1;  bus.req_op[0] = ALU_ADD;
    bus.req_a[1]  = 32'sd2;  bus.req_b[1] = 32'sd2;  bus.req_op[1] = ALU_ADD;
    bus.req_valid = 2'b11;
    bus.rsp_ready = 2'b11;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
`ifdef ALU_ARB_RR_EN
      chk("contend_grant", 32'(bus.req_ready), (k % 2 == 0) ? 32'h1 : 32'h2);
`else
      chk("contend_grant", 32'(bus.req_ready), 32'h1);
`endif
      step();
    end
    bus.req_valid = '0;
    step();
    bus.rsp_ready = '0;

    // Backpressure: result 100 + 23 held while requester 1 waits.
    bus.req_a[0]  = 32'sd100;
    bus.req_b[0]  = 32'sd23;
    bus.req_op[0] = ALU_ADD;
    bus.req_valid = 2'b01;
    step();
    bus.req_a[1]  = 32'sd1;
    bus.req_b[1]  = 32'sd2;
    bus.req_op[1] = ALU_ADD;
    bus.req_valid = 2'b10;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("bp_no_grant", 32'(bus.req_ready), 32'd0);
      chk("bp_rsp_valid", 32'(bus.rsp_valid), 32'h1);
      chk("bp_result", bus.rsp_result, 32'd123);
      step();
    end
    bus.rsp_ready = 2'b01;
    @(negedge clk);
    chk("bp_consume_grant", 32'(bus.req_ready), 32'h2);
    step();
    bus.rsp_ready = '0;
    bus.req_valid = '0;
    @(negedge clk);
    chk("bp_next_valid", 32'(bus.rsp_valid), 32'h2);
    chk("bp_next_result", bus.rsp_result, 32'd3);

    // Asynchronous reset while requester 1 holds a result.
    @(posedge clk);
    #2;
    nRst = 1'b0;
    #1;
    chk("arst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("arst_result", bus.rsp_result, 32'd0);
    bus.req_valid = 2'b11;
    #1;
    chk("arst_req_ready", 32'(bus.req_ready), 32'd0);
    step();
    nRst = 1'b1;
    @(negedge clk);
    chk("arst_first_grant", 32'(bus.req_ready), 32'h1);
    step();
    bus.req_valid = '0;
    bus.rsp_ready = 2'b11;
    step();
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
